// File: rtl/file_sched_pkg.sv
// rtl/file_sched_pkg.sv - shared types for the file job scheduler
package file_sched_pkg;

   typedef enum logic [1:0] {
      TEXT    = 2'd0,
      IMAGE   = 2'd1,
      VIDEO   = 2'd2,
      UNKNOWN = 2'd3
   } file_type_e;

   // Prefixed so the timeout status cannot collide with the TIMEOUT parameter.
   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_REJECT  = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPATCH = 2'd1,
      S_WAIT     = 2'd2,
      S_RESP     = 2'd3
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick starting one past the previous grant
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   always_comb begin
      int               cand;
      logic [IDX_W-1:0] sel;
      grant_idx = '0;
      any_req   = 1'b0;
      cand      = 0;
      sel       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(last_grant) + i) % NUM_REQ;
         sel  = IDX_W'(cand);
         if (!any_req && req[sel]) begin
            any_req   = 1'b1;
            grant_idx = sel;
         end
      end
   end

endmodule

// File: rtl/file_job_scheduler.sv
// rtl/file_job_scheduler.sv - shares one file handler among NUM_REQ requesters
module file_job_scheduler
   import file_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [2*NUM_REQ-1:0]       req_type,
   input  logic [ID_W*NUM_REQ-1:0]    req_id,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       hdl_start,
   output logic [1:0]                 hdl_type,
   output logic [ID_W-1:0]            hdl_id,
   input  logic                       hdl_done,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_req,
   output logic [1:0]                 rsp_status,
   output logic                       busy,
   output logic [7:0]                 done_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   sched_state_e       state_q;
   logic [IDX_W-1:0]   last_grant_q;
   logic [IDX_W-1:0]   winner_q;
   file_type_e         type_q;
   logic [ID_W-1:0]    id_q;
   logic [TMR_W-1:0]   timer_q;
   logic [NUM_REQ-1:0] ready_q;
   logic               start_q;
   logic               rsp_valid_q;
   status_e            status_q;
   logic               busy_q;
   logic [7:0]         done_cnt_q;

   logic [IDX_W-1:0]   grant_idx;
   logic               any_req;
   logic [1:0]         cap_type;
   logic [ID_W-1:0]    cap_id;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   always_comb begin
      cap_type = '0;
      cap_id   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            cap_type = req_type[2*i +: 2];
            cap_id   = req_id[ID_W*i +: ID_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         winner_q     <= '0;
         type_q       <= TEXT;
         id_q         <= '0;
         timer_q      <= '0;
         ready_q      <= '0;
         start_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         status_q     <= ST_OK;
         busy_q       <= 1'b0;
         done_cnt_q   <= '0;
      end else begin
         ready_q     <= '0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  // Strobes are set on entry so they are visible during DISPATCH.
                  winner_q <= grant_idx;
                  type_q   <= file_type_e'(cap_type);
                  id_q     <= cap_id;
                  ready_q  <= NUM_REQ'(1) << grant_idx;
                  start_q  <= (cap_type != UNKNOWN);
                  busy_q   <= 1'b1;
                  state_q  <= S_DISPATCH;
               end
            end
            S_DISPATCH: begin
               if (type_q == UNKNOWN) begin
                  status_q    <= ST_REJECT;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  timer_q <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               timer_q <= timer_q + TMR_W'(1);
               if (hdl_done) begin
                  status_q    <= ST_OK;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                  status_q    <= ST_TIMEOUT;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               last_grant_q <= winner_q;
               if (status_q == ST_OK) begin
                  done_cnt_q <= done_cnt_q + 8'd1;
               end
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign hdl_start  = start_q;
   assign hdl_type   = type_q;
   assign hdl_id     = id_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_req    = winner_q;
   assign rsp_status = status_q;
   assign busy       = busy_q;
   assign done_count = done_cnt_q;

endmodule

// File: tb/tb_file_job_scheduler.sv
// tb/tb_file_job_scheduler.sv - self-checking bench for file_job_scheduler
module tb_file_job_scheduler;

   localparam int N   = 4;
   localparam int IDW = 8;
   localparam int TO  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [2*N-1:0]   req_type;
   logic [IDW*N-1:0] req_id;
   logic [N-1:0]     req_ready;
   logic             hdl_start;
   logic [1:0]       hdl_type;
   logic [IDW-1:0]   hdl_id;
   logic             hdl_done;
   logic             rsp_valid;
   logic [1:0]       rsp_req;
   logic [1:0]       rsp_status;
   logic             busy;
   logic [7:0]       done_count;

   int checks   = 0;
   int failures = 0;
   int model_dc = 0;

   file_job_scheduler #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_type   (req_type),
      .req_id     (req_id),
      .req_ready  (req_ready),
      .hdl_start  (hdl_start),
      .hdl_type   (hdl_type),
      .hdl_id     (hdl_id),
      .hdl_done   (hdl_done),
      .rsp_valid  (rsp_valid),
      .rsp_req    (rsp_req),
      .rsp_status (rsp_status),
      .busy       (busy),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic [1:0] t, input logic [7:0] id);
      req_valid[r]          = v;
      req_type[2*r +: 2]    = t;
      req_id[IDW*r +: IDW]  = id;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req_valid = '0;
      req_type = '0;
      req_id = '0;
      hdl_done = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      model_dc = 0;
   endtask

   // Runs one job from capture to response; observes only, never compares.
   task automatic do_job(input int delay, input bit drop,
                         output int ack_idx, output int acks, output int starts,
                         output logic [1:0] t_seen, output logic [7:0] id_seen,
                         output int got_rsp, output int r_req, output int r_stat, output int lat);
      int d_cyc;
      int s_cyc;
      d_cyc = -1; s_cyc = -1;
      ack_idx = -1; acks = 0; starts = 0; t_seen = 0; id_seen = 0;
      got_rsp = 0; r_req = -1; r_stat = -1; lat = -1;
      for (int k = 0; k < 64 && got_rsp == 0; k++) begin
         tick;
         hdl_done = 1'b0;
         if (req_ready != '0) begin
            acks++;
            if (d_cyc < 0) d_cyc = k;
            if ($countones(req_ready) != 1) ack_idx = -2;
            else for (int i = 0; i < N; i++) if (req_ready[i]) ack_idx = i;
            if (drop && ack_idx >= 0) req_valid[ack_idx] = 1'b0;
         end
         if (hdl_start) begin
            starts++;
            s_cyc = k;
            t_seen = hdl_type;
            id_seen = hdl_id;
         end
         if (delay >= 0 && s_cyc >= 0 && k == s_cyc + delay) hdl_done = 1'b1;
         if (rsp_valid) begin
            got_rsp = 1;
            r_req = int'(rsp_req);
            r_stat = int'(rsp_status);
            lat = k - d_cyc;
         end
      end
      hdl_done = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = '1;
      req_type = '0;
      req_id = '1;
      hdl_done = 1'b1;
      tick;
      checks++;
      if ({req_ready, hdl_start, hdl_type, hdl_id, rsp_valid, rsp_req, rsp_status, busy, done_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b start=%b busy=%b dc=%0d, required all 0", req_ready, hdl_start, busy, done_count);
      end
      do_reset;
      tick;
      checks++;
      if (busy !== 1'b0 || req_ready !== '0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b ready=%b, required 0/0", busy, req_ready);
      end
   endtask

   task automatic test_single_job;
      int a, n, s, g, rr, st, l;
      logic [1:0] t;
      logic [7:0] id;
      set_req(1, 1'b1, 2'd0, 8'h11);
      do_job(3, 1'b1, a, n, s, t, id, g, rr, st, l);
      checks++;
      if (g != 1 || a != 1 || n != 1 || s != 1 || id !== 8'h11 || t !== 2'd0 || rr != 1 || st != 0 || l != 4) begin
         failures++;
         $display("FAIL single_job: rsp=%0d ack=%0d acks=%0d starts=%0d id=%h type=%0d req=%0d stat=%0d lat=%0d, required 1 1 1 1 11 0 1 0 4",
                  g, a, n, s, id, t, rr, st, l);
      end
      tick;
      model_dc = (model_dc + 1) % 256;
      checks++;
      if (done_count !== 8'(model_dc)) begin
         failures++;
         $display("FAIL single_done_count: got %0d required %0d", done_count, model_dc);
      end
   endtask

   task automatic test_reject;
      int a, n, s, g, rr, st, l;
      logic [1:0] t;
      logic [7:0] id;
      set_req(2, 1'b1, 2'd3, 8'h22);
      do_job(2, 1'b1, a, n, s, t, id, g, rr, st, l);
      checks++;
      if (g != 1 || a != 2 || s != 0 || rr != 2 || st != 1 || l != 1) begin
         failures++;
         $display("FAIL reject: rsp=%0d ack=%0d starts=%0d req=%0d stat=%0d lat=%0d, required 1 2 0 2 1 1", g, a, s, rr, st, l);
      end
      tick;
      checks++;
      if (done_count !== 8'(model_dc)) begin
         failures++;
         $display("FAIL reject_done_count: got %0d required %0d", done_count, model_dc);
      end
   endtask

   task automatic test_fairness;
      int a, n, s, g, rr, st, l;
      logic [1:0] t;
      logic [7:0] id;
      do_reset;
      for (int r = 0; r < N; r++) set_req(r, 1'b1, 2'(r % 3), 8'(8'h50 + r));
      for (int j = 0; j < 5; j++) begin
         do_job(2, 1'b0, a, n, s, t, id, g, rr, st, l);
         checks++;
         if (a != j % N || n != 1 || g != 1 || rr != j % N || id !== 8'(8'h50 + j % N)) begin
            failures++;
            $display("FAIL fairness_%0d: ack=%0d acks=%0d rsp=%0d req=%0d id=%h, required ack %0d once", j, a, n, g, rr, id, j % N);
         end
      end
      req_valid = '0;
      tick;
      model_dc = 5;
      checks++;
      if (done_count !== 8'(model_dc)) begin
         failures++;
         $display("FAIL fairness_done_count: got %0d required %0d", done_count, model_dc);
      end
   endtask

   task automatic test_timeout;
      int a, n, s, g, rr, st, l;
      int stray;
      logic [1:0] t;
      logic [7:0] id;
      set_req(0, 1'b1, 2'd1, 8'h33);
      do_job(-1, 1'b1, a, n, s, t, id, g, rr, st, l);
      checks++;
      if (g != 1 || s != 1 || rr != 0 || st != 2 || l != TO + 1) begin
         failures++;
         $display("FAIL timeout: rsp=%0d starts=%0d req=%0d stat=%0d lat=%0d, required 1 1 0 2 %0d", g, s, rr, st, l, TO + 1);
      end
      tick;
      hdl_done = 1'b1;
      tick;
      hdl_done = 1'b0;
      stray = 0;
      for (int k = 0; k < 5; k++) begin
         tick;
         if (rsp_valid || busy || hdl_start) stray++;
      end
      checks++;
      if (stray != 0 || done_count !== 8'(model_dc)) begin
         failures++;
         $display("FAIL stray_done: activity=%0d dc=%0d, required 0 and %0d", stray, done_count, model_dc);
      end
   endtask

   task automatic test_race;
      int a, n, s, g, rr, st, l;
      logic [1:0] t;
      logic [7:0] id;
      set_req(3, 1'b1, 2'd2, 8'h44);
      do_job(TO, 1'b1, a, n, s, t, id, g, rr, st, l);
      checks++;
      if (g != 1 || rr != 3 || st != 0 || l != TO + 1) begin
         failures++;
         $display("FAIL race: rsp=%0d req=%0d stat=%0d lat=%0d, required 1 3 0 %0d", g, rr, st, l, TO + 1);
      end
      tick;
      model_dc = (model_dc + 1) % 256;
   endtask

   task automatic test_reset_mid_wait;
      int a, n, s, g, rr, st, l;
      int stray;
      logic [1:0] t;
      logic [7:0] id;
      set_req(2, 1'b1, 2'd0, 8'h66);
      do_job(1, 1'b1, a, n, s, t, id, g, rr, st, l);
      set_req(2, 1'b1, 2'd1, 8'h77);
      tick;
      tick;
      req_valid = '0;
      tick;
      tick;
      checks++;
      if (busy !== 1'b1 || hdl_id !== 8'h77) begin
         failures++;
         $display("FAIL mid_wait_setup: busy=%b id=%h, required 1 77", busy, hdl_id);
      end
      rst = 1'b1;
      #2;
      checks++;
      if ({req_ready, hdl_start, hdl_type, hdl_id, rsp_valid, rsp_req, rsp_status, busy, done_count} !== '0) begin
         failures++;
         $display("FAIL mid_wait_reset_outputs: busy=%b id=%h dc=%0d, required all 0", busy, hdl_id, done_count);
      end
      tick;
      rst = 1'b0;
      model_dc = 0;
      hdl_done = 1'b1;
      tick;
      hdl_done = 1'b0;
      stray = 0;
      for (int k = 0; k < 4; k++) begin
         tick;
         if (rsp_valid || busy) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL mid_wait_no_rsp: activity=%0d required 0", stray);
      end
      set_req(0, 1'b1, 2'd3, 8'h01);
      set_req(3, 1'b1, 2'd3, 8'h03);
      do_job(-1, 1'b1, a, n, s, t, id, g, rr, st, l);
      checks++;
      if (a != 0 || rr != 0) begin
         failures++;
         $display("FAIL post_reset_priority: ack=%0d req=%0d, required 0 0", a, rr);
      end
      req_valid = '0;
      tick;
   endtask

   task automatic test_random;
      bit         pend[N];
      logic [1:0] mt[N];
      logic [7:0] mi[N];
      int lg, w, dly, any, ex_stat, ex_lat, ex_starts;
      int a, n, s, g, rr, st, l;
      logic [1:0] t;
      logic [7:0] id;
      do_reset;
      lg = N - 1;
      for (int r = 0; r < N; r++) begin pend[r] = 0; mt[r] = 0; mi[r] = 0; end
      for (int j = 0; j < 40; j++) begin
         any = 0;
         for (int r = 0; r < N; r++) begin
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r] = 1;
               mt[r] = 2'($urandom_range(0, 3));
               mi[r] = 8'($urandom);
            end else if (pend[r] && $urandom_range(0, 7) == 0) begin
               pend[r] = 0;
            end
            if (pend[r]) any = 1;
         end
         if (any == 0) begin
            w = $urandom_range(0, N - 1);
            pend[w] = 1;
            mt[w] = 2'($urandom_range(0, 3));
            mi[w] = 8'($urandom);
         end
         for (int r = 0; r < N; r++) set_req(r, pend[r], mt[r], mi[r]);
         w = -1;
         for (int k = 1; k <= N; k++) if (w < 0 && pend[(lg + k) % N]) w = (lg + k) % N;
         dly = $urandom_range(0, TO + 3);
         if (dly == TO + 3) dly = -1;
         if (mt[w] == 2'd3) begin
            ex_starts = 0; ex_stat = 1; ex_lat = 1;
         end else if (dly >= 1 && dly <= TO) begin
            ex_starts = 1; ex_stat = 0; ex_lat = dly + 1;
            model_dc = (model_dc + 1) % 256;
         end else begin
            ex_starts = 1; ex_stat = 2; ex_lat = TO + 1;
         end
         do_job(dly, 1'b1, a, n, s, t, id, g, rr, st, l);
         checks++;
         if (g != 1 || a != w || n != 1 || rr != w || s != ex_starts || st != ex_stat || l != ex_lat
             || (ex_starts == 1 && (id !== mi[w] || t !== mt[w]))) begin
            failures++;
            $display("FAIL random_%0d: ack=%0d req=%0d starts=%0d stat=%0d lat=%0d id=%h, required %0d %0d %0d %0d %0d %h (delay %0d)",
                     j, a, rr, s, st, l, id, w, w, ex_starts, ex_stat, ex_lat, mi[w], dly);
         end
         pend[w] = 0;
         lg = w;
      end
      req_valid = '0;
      tick;
      checks++;
      if (done_count !== 8'(model_dc)) begin
         failures++;
         $display("FAIL random_done_count: got %0d required %0d", done_count, model_dc);
      end
   endtask

   initial begin
      test_reset;
      test_single_job;
      test_reject;
      test_fairness;
      test_timeout;
      test_race;
      test_reset_mid_wait;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
